// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational alu: registers one command,
// drives the alu for one cycle, accumulates the result, and returns it with a wrap flag.
module alu_issue_ctrl #(
  parameter int unsigned SIZE = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic            cmd_use_acc_i,
  input  logic [SIZE:0]   cmd_a_i,
  input  logic [SIZE:0]   cmd_b_i,
  output logic [1:0]      alu_operator_o,
  output logic [SIZE:0]   alu_operand_a_o,
  output logic [SIZE:0]   alu_operand_b_o,
  input  logic [SIZE:0]   alu_result_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [SIZE:0]   res_data_o,
  output logic            res_wrap_o,
  output logic [SIZE:0]   acc_o
);

  localparam int unsigned W = SIZE + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     alu_op_q, alu_op_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic           res_wrap_q, res_wrap_d;
  logic           res_valid_q, res_valid_d;
  logic           cmd_ready_q, cmd_ready_d;

  logic [W-1:0]   exec_result;
  logic           exec_wrap;

  // Result/wrap for the latched command; wrap never depends on the alu.
  always_comb begin
    exec_result = '0;
    exec_wrap   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        exec_result = alu_result_i;
        // Truncated sum smaller than an addend <=> carry out of the MSB.
        exec_wrap   = W'(a_q + b_q) < a_q;
      end
      OP_SUB: begin
        exec_result = alu_result_i;
        exec_wrap   = a_q < b_q;
      end
      OP_CLR: begin
        exec_result = '0;
        exec_wrap   = 1'b0;
      end
      OP_LOAD: begin
        exec_result = b_q;
        exec_wrap   = 1'b0;
      end
      default: begin
        exec_result = '0;
        exec_wrap   = 1'b0;
      end
    endcase
  end

  // Next-state and register updates for IDLE -> EXEC -> RESP.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_wrap_d  = res_wrap_q;
    res_valid_d = res_valid_q;
    cmd_ready_d = cmd_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d        = cmd_op_i;
          a_d         = cmd_use_acc_i ? acc_q : cmd_a_i;
          b_d         = cmd_b_i;
          alu_op_d    = cmd_op_i[1] ? OP_ADD : cmd_op_i;
          cmd_ready_d = 1'b0;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d  = exec_result;
        res_wrap_d  = exec_wrap;
        acc_d       = exec_result;
        res_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_op_q    <= OP_ADD;
      res_data_q  <= '0;
      res_wrap_q  <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_wrap_q  <= res_wrap_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign alu_operator_o  = alu_op_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_wrap_o      = res_wrap_q;
  assign acc_o           = acc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed cases plus a random ADD/SUB stream,
// with a behavioural alu and an arithmetic reference model.
module tb_alu_issue_ctrl;
  localparam int unsigned SIZE = 7;
  localparam int unsigned W    = SIZE + 1;
  localparam int          MOD  = 1 << W;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [1:0]     cmd_op_i;
  logic           cmd_use_acc_i;
  logic [W-1:0]   cmd_a_i, cmd_b_i;
  logic [1:0]     alu_operator_o;
  logic [W-1:0]   alu_operand_a_o, alu_operand_b_o, alu_result_i;
  logic           res_valid_o, res_ready_i, res_wrap_o;
  logic [W-1:0]   res_data_o, acc_o;

  always #5 clk_i = ~clk_i;

  alu_issue_ctrl #(.SIZE(SIZE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_use_acc_i(cmd_use_acc_i),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
    .alu_operand_b_o(alu_operand_b_o), .alu_result_i(alu_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_wrap_o(res_wrap_o), .acc_o(acc_o)
  );

  // Behavioural combinational alu: 00 add, 01 sub.
  always_comb begin
    if (alu_operator_o == 2'b01) alu_result_i = W'(int'(alu_operand_a_o) - int'(alu_operand_b_o));
    else                         alu_result_i = W'(int'(alu_operand_a_o) + int'(alu_operand_b_o));
  end

  // Response-ready source: fixed level or a random bit per cycle.
  logic fixed_ready, rand_mode, rand_bit;
  assign res_ready_i = rand_mode ? rand_bit : fixed_ready;
  always @(posedge clk_i) rand_bit <= 1'($urandom_range(0, 1));

  typedef struct { int data; int wrap; } exp_t;
  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   n_push = 0, n_pop = 0, n_disc = 0;
  int   model_acc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on integers, returns effective operand A.
  task automatic model_push(input int op, input int use_acc, input int a, input int b,
                            output int a_eff);
    exp_t e;
    a_eff = use_acc ? model_acc : a;
    case (op)
      0:       begin e.data = (a_eff + b) % MOD;       e.wrap = (a_eff + b >= MOD) ? 1 : 0; end
      1:       begin e.data = (a_eff - b + MOD) % MOD; e.wrap = (a_eff < b) ? 1 : 0;       end
      2:       begin e.data = 0;                       e.wrap = 0;                          end
      default: begin e.data = b;                       e.wrap = 0;                          end
    endcase
    model_acc = e.data;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Monitor: compares every presented response against the queue head.
  always @(negedge clk_i) begin
    if (!rst_i && res_valid_o) begin
      check("ready_low_in_resp", int'(cmd_ready_o), 0);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp: got data %0d with no expected entry", res_data_o);
      end else begin
        check("res_data", int'(res_data_o), exp_q[0].data);
        check("res_wrap", int'(res_wrap_o), exp_q[0].wrap);
        check("acc_o",    int'(acc_o),      exp_q[0].data);
        if (res_ready_i) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  task automatic issue(input int op, input int use_acc, input int a, input int b);
    bit ok = 1'b0;
    int a_eff;
    cmd_op_i      = 2'(op);
    cmd_use_acc_i = 1'(use_acc);
    cmd_a_i       = W'(a);
    cmd_b_i       = W'(b);
    cmd_valid_i   = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_i);
      ok = cmd_ready_o;
      @(posedge clk_i);
    end
    #1 cmd_valid_i = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept op %0d", op);
      return;
    end
    model_push(op, use_acc, a, b, a_eff);
    check("exec_alu_op", int'(alu_operator_o), (op >= 2) ? 0 : op);
    check("exec_alu_a",  int'(alu_operand_a_o), a_eff);
    check("exec_alu_b",  int'(alu_operand_b_o), b);
    check("exec_no_valid", int'(res_valid_o), 0);
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin
      @(posedge clk_i);
      cnt++;
    end
    #1;
    check("drain_done", exp_q.size(), 0);
  endtask

  // Directed command: literal expectations at N+2, then drain.
  task automatic issue_expect(input string name, input int op, input int use_acc,
                              input int a, input int b, input int exp_d, input int exp_w);
    issue(op, use_acc, a, b);
    @(posedge clk_i); #1;
    check({name, "_valid_n2"}, int'(res_valid_o), 1);
    check({name, "_data"},     int'(res_data_o),  exp_d);
    check({name, "_wrap"},     int'(res_wrap_o),  exp_w);
    check({name, "_acc"},      int'(acc_o),       exp_d);
    drain();
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_use_acc_i = 1'b0;
    cmd_a_i = '0; cmd_b_i = '0; fixed_ready = 1'b1; rand_mode = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", int'(res_valid_o), 0);
    check("rst_data",  int'(res_data_o), 0);
    check("rst_wrap",  int'(res_wrap_o), 0);
    check("rst_alu_op", int'(alu_operator_o), 0);
    check("rst_acc",   int'(acc_o), 0);
    check("rst_ready", int'(cmd_ready_o), 1);
    rst_i = 1'b0;

    issue_expect("add_200_100", 0, 0, 200, 100, 44, 1);
    issue_expect("sub_5_9",     1, 0, 5, 9, 252, 1);
    issue_expect("sub_acc_2",   1, 1, 0, 2, 250, 0);
    issue_expect("load_7f",     3, 0, 0, 8'h7f, 8'h7f, 0);
    issue_expect("add_acc_1",   0, 1, 0, 1, 8'h80, 0);
    issue_expect("clr",         2, 0, 33, 77, 0, 0);

    // Reset mid-RESP discards the response.
    fixed_ready = 1'b0;
    issue(0, 0, 1, 2);
    @(posedge clk_i); #1;
    check("pre_rst_valid", int'(res_valid_o), 1);
    rst_i = 1'b1;
    n_disc += exp_q.size();
    exp_q.delete();
    model_acc = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("mid_rst_valid", int'(res_valid_o), 0);
    check("mid_rst_acc",   int'(acc_o), 0);
    @(posedge clk_i); #1;
    check("post_rst_ready", int'(cmd_ready_o), 1);
    check("post_rst_valid", int'(res_valid_o), 0);
    fixed_ready = 1'b1;

    // Backpressure stall with a command presented that must not be taken.
    fixed_ready = 1'b0;
    issue(0, 0, 17, 25);
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) begin
      cmd_op_i = 2'b00; cmd_a_i = 8'd99; cmd_b_i = 8'd1; cmd_use_acc_i = 1'b0;
      cmd_valid_i = (i >= 1 && i <= 3);
      @(posedge clk_i); #1;
      check("stall_valid", int'(res_valid_o), 1);
      check("stall_data",  int'(res_data_o), 42);
      check("stall_ready", int'(cmd_ready_o), 0);
    end
    cmd_valid_i = 1'b0;
    fixed_ready = 1'b1;
    drain();
    check("after_stall_ready", int'(cmd_ready_o), 1);
    repeat (3) @(posedge clk_i);
    #1;
    check("stall_cmd_not_consumed", int'(res_valid_o), 0);
    check("stall_acc_kept", int'(acc_o), 42);

    // Random ADD/SUB stream with random gaps and random response backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      issue(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
    end
    drain();
    rand_mode = 1'b0;
    check("no_lost_or_dup", n_pop, n_push - n_disc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
